// File: rtl/ws2812_pkg.sv
// Shared pixel format for the WS2812 framebuffer: 24-bit GRB-agnostic pixel
// packed as {r, g, b}, plus the index width used on the host and strip sides.
package ws2812_pkg;

   localparam int PIXEL_W = 24;
   localparam int INDEX_W = 9;

   localparam int R_MSB = 23;
   localparam int R_LSB = 16;
   localparam int G_MSB = 15;
   localparam int G_LSB = 8;
   localparam int B_MSB = 7;
   localparam int B_LSB = 0;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } pixel_t;

   // Bits needed to index one bank of n pixels (at least one bit).
   function automatic int bank_index_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel store: one synchronous write port, one registered
// read port. Maps onto a single block RAM.
module ws2812_pixel_ram
   import ws2812_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic               clk_i,
   input  logic               we,
   input  logic [ADDR_W-1:0]  waddr,
   input  logic [PIXEL_W-1:0] wdata,
   input  logic [ADDR_W-1:0]  raddr,
   output logic [PIXEL_W-1:0] rdata
);

   logic [PIXEL_W-1:0] mem_reg [0:(1 << ADDR_W) - 1];

   always_ff @(posedge clk_i) begin
      if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   always_ff @(posedge clk_i) begin
      rdata <= mem_reg[raddr];
   end

endmodule

// File: rtl/ws2812_framebuffer.sv
// Double-buffered WS2812 pixel store: host fills the back bank, a commit swaps
// banks at the next strip reset gap (read address held stable long enough).
module ws2812_framebuffer
   import ws2812_pkg::*;
#(
   parameter int LED_COUNT        = 256,
   parameter int SYNC_IDLE_CYCLES = 2048
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [INDEX_W-1:0] host_addr_i,
   input  logic [PIXEL_W-1:0] host_data_i,
   input  logic               host_we_i,
   input  logic               commit_i,
   output logic               commit_pending_o,
   output logic               swap_o,
   input  logic [INDEX_W-1:0] address_i,
   output logic [7:0]         r_o,
   output logic [7:0]         g_o,
   output logic [7:0]         b_o
);

   localparam int IDX_W = bank_index_width(LED_COUNT);
   localparam int RAM_W = IDX_W + 1;
   localparam int CNT_W = (SYNC_IDLE_CYCLES > 1) ? $clog2(SYNC_IDLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_IDLE_CYCLES - 1);
   localparam logic [INDEX_W:0] LED_LIMIT = (INDEX_W + 1)'(LED_COUNT);

   logic               bank_sel_reg;
   logic               pending_reg;
   logic               blank_reg;
   logic               swap_reg;
   logic               zero_reg;
   logic [INDEX_W-1:0] addr_prev_reg;
   logic [CNT_W-1:0]   cnt_reg;
   logic [CNT_W-1:0]   cnt_next;
   logic               idle_evt;
   logic               host_in_range;
   logic               rd_in_range;
   logic               ram_we;
   logic [RAM_W-1:0]   ram_waddr;
   logic [RAM_W-1:0]   ram_raddr;
   logic [PIXEL_W-1:0] ram_rdata;

   assign host_in_range = {1'b0, host_addr_i} < LED_LIMIT;
   assign rd_in_range   = {1'b0, address_i} < LED_LIMIT;

   // Bank bit is the RAM address MSB; host always targets the current back bank.
   assign ram_we    = host_we_i && host_in_range;
   assign ram_waddr = {~bank_sel_reg, host_addr_i[IDX_W-1:0]};
   assign ram_raddr = {bank_sel_reg, address_i[IDX_W-1:0]};

   always_comb begin
      cnt_next = '0;
      if (address_i == addr_prev_reg) begin
         cnt_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
      end
   end

   // Fires only on the transition into saturation, so a long gap swaps once.
   assign idle_evt = (cnt_next == CNT_MAX) && (cnt_reg != CNT_MAX);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bank_sel_reg  <= 1'b0;
         pending_reg   <= 1'b0;
         blank_reg     <= 1'b1;
         swap_reg      <= 1'b0;
         zero_reg      <= 1'b1;
         addr_prev_reg <= '0;
         cnt_reg       <= '0;
      end else begin
         addr_prev_reg <= address_i;
         cnt_reg       <= cnt_next;
         swap_reg      <= 1'b0;
         zero_reg      <= blank_reg || !rd_in_range;
         if (idle_evt && pending_reg) begin
            bank_sel_reg <= ~bank_sel_reg;
            pending_reg  <= 1'b0;
            blank_reg    <= 1'b0;
            swap_reg     <= 1'b1;
         end else if (commit_i) begin
            pending_reg <= 1'b1;
         end
      end
   end

   ws2812_pixel_ram #(
      .ADDR_W (RAM_W)
   ) u_pixel_ram (
      .clk_i (clk_i),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (host_data_i),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign commit_pending_o = pending_reg;
   assign swap_o           = swap_reg;
   assign r_o = zero_reg ? 8'h00 : ram_rdata[R_MSB:R_LSB];
   assign g_o = zero_reg ? 8'h00 : ram_rdata[G_MSB:G_LSB];
   assign b_o = zero_reg ? 8'h00 : ram_rdata[B_MSB:B_LSB];

endmodule
